// File: rtl/frame_dump_pkg.sv
// Shared types and constants for the frame dump sequencer.
package frame_dump_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC0 = 3'd1,
    ST_SYNC1 = 3'd2,
    ST_ADDR  = 3'd3,
    ST_LATCH = 3'd4,
    ST_SEND  = 3'd5,
    ST_CSUM  = 3'd6,
    ST_DONE  = 3'd7
  } state_e;

  localparam logic [7:0] DEF_SYNC0      = 8'hA5;
  localparam logic [7:0] DEF_SYNC1      = 8'h5A;
  localparam int         BYTES_PER_WORD = 4;

  // Modulo-256 running sum of payload bytes.
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/frame_dump_ctrl_uart_pacer.sv
// Idle-gap pacer: a byte may be written only after the UART has been quiet
// for a full counter span.
module uart_pacer #(
  parameter int HOLDOFF_BITS = 13
) (
  input  logic clk,
  input  logic rst_n,
  input  logic uart_busy_i,
  input  logic uart_wr_o,
  output logic ready
);

  logic [HOLDOFF_BITS-1:0] cnt_r;

  // Holdoff counter: cleared by any UART activity, otherwise saturating up-count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {HOLDOFF_BITS{1'b0}};
    end else if (uart_busy_i || uart_wr_o) begin
      cnt_r <= {HOLDOFF_BITS{1'b0}};
    end else if (!(&cnt_r)) begin
      cnt_r <= cnt_r + {{(HOLDOFF_BITS-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign ready = (&cnt_r) && !uart_busy_i && !uart_wr_o;

endmodule

// File: rtl/frame_dump_ctrl.sv
// Streams the downsampled buffer over the UART as sync header + MSB-first words.
// Optional trailing checksum byte when FRAME_DUMP_CHECKSUM_EN is defined.
module frame_dump_ctrl
  import frame_dump_pkg::*;
#(
  parameter int          WIDTH        = 40,
  parameter int          HEIGHT       = 30,
  parameter int          XW           = 6,
  parameter int          YW           = 5,
  parameter int          HOLDOFF_BITS = 13,
  parameter int          CONTINUOUS   = 1,
  parameter logic [7:0]  SYNC0        = DEF_SYNC0,
  parameter logic [7:0]  SYNC1        = DEF_SYNC1
) (
  input  logic          sys_clk_i,
  input  logic          sys_rst_n_i,
  input  logic          start_i,
  input  logic          abort_i,
  output logic [XW-1:0] read_x_o,
  output logic [YW-1:0] read_y_o,
  input  logic [31:0]   read_data_i,
  output logic          uart_wr_o,
  output logic [7:0]    uart_dat_o,
  input  logic          uart_busy_i,
  output logic          busy_o,
  output logic          frame_done_o
);

  state_e        state_r, state_s;
  logic [XW-1:0] x_r, x_s;
  logic [YW-1:0] y_r, y_s;
  logic [31:0]   shreg_r, shreg_s;
  logic [1:0]    idx_r, idx_s;
  logic          wr_r, wr_s;
  logic [7:0]    dat_r, dat_s;
  logic          done_r, done_s;
  logic          busy_r, busy_s;
  logic          ready_s;
  logic          last_x_s, last_y_s;
`ifdef FRAME_DUMP_CHECKSUM_EN
  logic [7:0]    csum_r, csum_s;
`endif

  uart_pacer #(.HOLDOFF_BITS(HOLDOFF_BITS)) u_pacer (
    .clk         (sys_clk_i),
    .rst_n       (sys_rst_n_i),
    .uart_busy_i (uart_busy_i),
    .uart_wr_o   (wr_r),
    .ready       (ready_s)
  );

  assign last_x_s = (x_r == XW'(WIDTH - 1));
  assign last_y_s = (y_r == YW'(HEIGHT - 1));

  // Next-state, address walk and next values of all registered outputs.
  always_comb begin
    state_s = state_r;
    x_s     = x_r;
    y_s     = y_r;
    shreg_s = shreg_r;
    idx_s   = idx_r;
    wr_s    = 1'b0;
    dat_s   = dat_r;
    done_s  = 1'b0;
`ifdef FRAME_DUMP_CHECKSUM_EN
    csum_s  = csum_r;
`endif
    if (abort_i && (state_r != ST_IDLE)) begin
      state_s = ST_IDLE;
      x_s     = {XW{1'b0}};
      y_s     = {YW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          x_s = {XW{1'b0}};
          y_s = {YW{1'b0}};
          if (start_i || (CONTINUOUS != 0)) begin
            state_s = ST_SYNC0;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_SYNC0: begin
`ifdef FRAME_DUMP_CHECKSUM_EN
          csum_s = 8'h00;
`endif
          if (ready_s) begin
            wr_s    = 1'b1;
            dat_s   = SYNC0;
            state_s = ST_SYNC1;
          end else begin
            state_s = ST_SYNC0;
          end
        end
        ST_SYNC1: begin
          if (ready_s) begin
            wr_s    = 1'b1;
            dat_s   = SYNC1;
            state_s = ST_ADDR;
          end else begin
            state_s = ST_SYNC1;
          end
        end
        // Address has been on the buffer port for this cycle; data lands next.
        ST_ADDR:  state_s = ST_LATCH;
        ST_LATCH: begin
          shreg_s = read_data_i;
          idx_s   = 2'd0;
          state_s = ST_SEND;
        end
        ST_SEND: begin
          if (ready_s) begin
            wr_s    = 1'b1;
            dat_s   = shreg_r[31:24];
            shreg_s = {shreg_r[23:0], 8'h00};
            idx_s   = idx_r + 2'd1;
`ifdef FRAME_DUMP_CHECKSUM_EN
            csum_s  = csum_add(csum_r, shreg_r[31:24]);
`endif
            if (idx_r == 2'(BYTES_PER_WORD - 1)) begin
              if (last_x_s && last_y_s) begin
`ifdef FRAME_DUMP_CHECKSUM_EN
                state_s = ST_CSUM;
`else
                state_s = ST_DONE;
`endif
              end else if (last_x_s) begin
                x_s     = {XW{1'b0}};
                y_s     = y_r + YW'(1);
                state_s = ST_ADDR;
              end else begin
                x_s     = x_r + XW'(1);
                state_s = ST_ADDR;
              end
            end else begin
              state_s = ST_SEND;
            end
          end else begin
            state_s = ST_SEND;
          end
        end
        ST_CSUM: begin
`ifdef FRAME_DUMP_CHECKSUM_EN
          if (ready_s) begin
            wr_s    = 1'b1;
            dat_s   = csum_r;
            state_s = ST_DONE;
          end else begin
            state_s = ST_CSUM;
          end
`else
          state_s = ST_IDLE;
`endif
        end
        ST_DONE: begin
          done_s  = 1'b1;
          state_s = ST_IDLE;
        end
        default: state_s = ST_IDLE;
      endcase
    end
    busy_s = (state_s != ST_IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      state_r <= ST_IDLE;
      x_r     <= {XW{1'b0}};
      y_r     <= {YW{1'b0}};
      shreg_r <= 32'h0000_0000;
      idx_r   <= 2'd0;
      wr_r    <= 1'b0;
      dat_r   <= 8'h00;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      x_r     <= x_s;
      y_r     <= y_s;
      shreg_r <= shreg_s;
      idx_r   <= idx_s;
      wr_r    <= wr_s;
      dat_r   <= dat_s;
      done_r  <= done_s;
      busy_r  <= busy_s;
    end
  end

`ifdef FRAME_DUMP_CHECKSUM_EN
  // Payload checksum accumulator.
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      csum_r <= 8'h00;
    end else begin
      csum_r <= csum_s;
    end
  end
`endif

  assign read_x_o     = x_r;
  assign read_y_o     = y_r;
  assign uart_wr_o    = wr_r;
  assign uart_dat_o   = dat_r;
  assign busy_o       = busy_r;
  assign frame_done_o = done_r;

endmodule

// File: tb/tb_frame_dump_ctrl.sv
// Bench for frame_dump_ctrl: two instances (single-shot and continuous) with
// buffer/UART models; expected byte streams derived from the buffer contents.
module tb_frame_dump_ctrl;

  localparam int W = 2;
  localparam int H = 2;
`ifdef FRAME_DUMP_CHECKSUM_EN
  localparam int FLEN = 2 + 4 * W * H + 1;
`else
  localparam int FLEN = 2 + 4 * W * H;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, start_a, start_b, abort_a, abort_b;
  logic [5:0] xa, xb;
  logic [4:0] ya, yb;
  logic [31:0] rda, rdb;
  logic wra, wrb, ubusy_a, ubusy_b, bsya, bsyb, donea, doneb;
  logic [7:0] data, datb;

  logic [31:0] mem_a [4];
  logic [31:0] mem_b [4];
  int bcnt_a = 0, bcnt_b = 0;

  logic [7:0] cap_a[$], cap_b[$], exp_q[$];
  int dsize_b[$];
  int ndone_a = 0, gap_a = 0, gap_b = 0, mingap_a = 1000, mingap_b = 1000;
  int wbusy = 0, badaddr = 0;
  int vectors = 0, miscompares = 0;

  frame_dump_ctrl #(.WIDTH(W), .HEIGHT(H), .HOLDOFF_BITS(3), .CONTINUOUS(0)) dut_a (
    .sys_clk_i(clk), .sys_rst_n_i(rst_a), .start_i(start_a), .abort_i(abort_a),
    .read_x_o(xa), .read_y_o(ya), .read_data_i(rda), .uart_wr_o(wra),
    .uart_dat_o(data), .uart_busy_i(ubusy_a), .busy_o(bsya), .frame_done_o(donea));

  frame_dump_ctrl #(.WIDTH(W), .HEIGHT(H), .HOLDOFF_BITS(3), .CONTINUOUS(1)) dut_b (
    .sys_clk_i(clk), .sys_rst_n_i(rst_b), .start_i(start_b), .abort_i(abort_b),
    .read_x_o(xb), .read_y_o(yb), .read_data_i(rdb), .uart_wr_o(wrb),
    .uart_dat_o(datb), .uart_busy_i(ubusy_b), .busy_o(bsyb), .frame_done_o(doneb));

  // Buffer read ports (one-cycle latency) and UART busy models.
  always @(posedge clk) begin
    rda <= mem_a[int'(ya) * W + int'(xa)];
    rdb <= mem_b[int'(yb) * W + int'(xb)];
    if (wra) bcnt_a <= 10;
    else if (bcnt_a > 0) bcnt_a <= bcnt_a - 1;
    if (wrb) bcnt_b <= int'($urandom_range(4, 14));
    else if (bcnt_b > 0) bcnt_b <= bcnt_b - 1;
  end
  assign ubusy_a = (bcnt_a != 0);
  assign ubusy_b = (bcnt_b != 0);

  // Byte capture, pacing and address-range monitors.
  always @(negedge clk) begin
    if (wra) begin
      cap_a.push_back(data);
      if (gap_a < mingap_a) mingap_a <= gap_a;
      gap_a <= 0;
    end else if (!ubusy_a) gap_a <= gap_a + 1;
    else gap_a <= 0;
    if (wrb) begin
      cap_b.push_back(datb);
      if (gap_b < mingap_b) mingap_b <= gap_b;
      gap_b <= 0;
    end else if (!ubusy_b) gap_b <= gap_b + 1;
    else gap_b <= 0;
    if ((wra && ubusy_a) || (wrb && ubusy_b)) wbusy <= wbusy + 1;
    if (donea) ndone_a <= ndone_a + 1;
    if (doneb) dsize_b.push_back(cap_b.size());
    if (xa > 6'd1 || ya > 5'd1 || xb > 6'd1 || yb > 5'd1) badaddr <= badaddr + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference frame: header, words in raster order MSB byte first, optional sum.
  task automatic build_exp(input int which);
    logic [31:0] w;
    logic [7:0] b;
    int sum;
    sum = 0;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        w = (which == 0) ? mem_a[y * W + x] : mem_b[y * W + x];
        for (int k = 3; k >= 0; k--) begin
          b = w[8 * k +: 8];
          exp_q.push_back(b);
          sum = (sum + int'(b)) % 256;
        end
      end
`ifdef FRAME_DUMP_CHECKSUM_EN
    exp_q.push_back(8'(sum));
`endif
  endtask

  task automatic cmp_bytes(input string tag, input int which, input int base, input int n);
    for (int i = 0; i < n; i++)
      chk(tag, (which == 0) ? cap_a[base + i] : cap_b[base + i], exp_q[i]);
  endtask

  task automatic wait_cap(input int which, input int target, input int budget);
    for (int i = 0; i < budget && ((which == 0) ? cap_a.size() : cap_b.size()) < target; i++)
      @(negedge clk);
    chk("wait_bytes", (which == 0) ? cap_a.size() : cap_b.size(), target);
  endtask

  task automatic pulse_start(input logic with_abort);
    @(posedge clk); #1 start_a = 1'b1; abort_a = with_abort;
    @(posedge clk); #1 start_a = 1'b0; abort_a = 1'b0;
  endtask

  initial begin
    int base, d0, nd;
    rst_a = 1'b0; rst_b = 1'b0; start_a = 1'b0; start_b = 1'b0; abort_a = 1'b0; abort_b = 1'b0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        mem_a[y * W + x] = {4{4'(y), 4'(x)}};
    for (int i = 0; i < 4; i++) mem_b[i] = $urandom;
`ifdef FRAME_DUMP_CHECKSUM_EN
    for (int i = 0; i < 4; i++) mem_b[i] = 32'h01020304;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_a", {10'd0, wra, data, bsya, donea, xa, ya}, 32'd0);
    chk("reset_b", {10'd0, wrb, datb, bsyb, doneb, xb, yb}, 32'd0);
    rst_a = 1'b1;

    // Single frame with the indexed pattern.
    base = cap_a.size(); d0 = ndone_a;
    repeat (4) @(posedge clk);
    chk("idle_no_start", {31'd0, bsya}, 32'd0);
    pulse_start(1'b0);
    for (int i = 0; i < 3000 && ndone_a < d0 + 1; i++) @(posedge clk);
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("frame1_done", ndone_a, d0 + 1);
    chk("frame1_len", cap_a.size() - base, FLEN);
    build_exp(0);
    cmp_bytes("frame1_byte", 0, base, FLEN);
    chk("frame1_idle", {31'd0, bsya}, 32'd0);

    // Abort after the seventh byte.
    for (int i = 0; i < 4; i++) mem_a[i] = $urandom;
    base = cap_a.size(); d0 = ndone_a;
    pulse_start(1'b0);
    wait_cap(0, base + 7, 3000);
    @(posedge clk); #1 abort_a = 1'b1;
    @(posedge clk); #1 abort_a = 1'b0;
    repeat (400) @(posedge clk);
    @(negedge clk);
    chk("abort_len", cap_a.size() - base, 7);
    chk("abort_no_done", ndone_a, d0);
    chk("abort_idle", {31'd0, bsya}, 32'd0);
    build_exp(0);
    cmp_bytes("abort_byte", 0, base, 7);

    // Start together with abort in IDLE; start re-pulsed mid-frame is ignored.
    for (int i = 0; i < 4; i++) mem_a[i] = $urandom;
    base = cap_a.size(); d0 = ndone_a;
    pulse_start(1'b1);
    wait_cap(0, base + 3, 3000);
    pulse_start(1'b0);
    for (int i = 0; i < 3000 && ndone_a < d0 + 1; i++) @(posedge clk);
    repeat (300) @(posedge clk);
    @(negedge clk);
    chk("restart_done", ndone_a, d0 + 1);
    chk("restart_len", cap_a.size() - base, FLEN);
    build_exp(0);
    cmp_bytes("restart_byte", 0, base, FLEN);

    // Continuous instance: back-to-back frames.
    rst_b = 1'b1;
    for (int i = 0; i < 8000 && dsize_b.size() < 2; i++) @(posedge clk);
    @(negedge clk);
    chk("cont_frames", dsize_b.size(), 2);
    chk("cont_size0", dsize_b[0], FLEN);
    chk("cont_size1", dsize_b[1], 2 * FLEN);
    build_exp(1);
    cmp_bytes("cont_f0_byte", 1, 0, FLEN);
    cmp_bytes("cont_f1_byte", 1, FLEN, FLEN);
`ifdef FRAME_DUMP_CHECKSUM_EN
    chk("csum_byte", cap_b[FLEN - 1], 32'h28);
`endif

    // Asynchronous reset in the middle of a word.
    wait_cap(1, 2 * FLEN + 5, 3000);
    @(negedge clk);
    rst_b = 1'b0;
    #1;
    chk("mid_reset_outs", {10'd0, wrb, datb, bsyb, doneb, xb, yb}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    base = cap_b.size(); nd = dsize_b.size();
    for (int i = 0; i < 4000 && dsize_b.size() < nd + 1; i++) @(posedge clk);
    @(negedge clk);
    chk("post_reset_frames", dsize_b.size(), nd + 1);
    chk("post_reset_len", dsize_b[nd] - base, FLEN);
    cmp_bytes("post_reset_byte", 1, base, FLEN);

    chk("min_gap_a", {31'd0, mingap_a >= 8}, 32'd1);
    chk("min_gap_b", {31'd0, mingap_b >= 8}, 32'd1);
    chk("write_while_busy", wbusy, 0);
    chk("addr_range", badaddr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
